// File: rtl/context_quant.sv
// Context quantizer for a near-lossless image coder: quantizes three local
// gradients into a merged context index, forms the MED prediction and tags
// every pixel with its frame position. Fixed 2-stage pipeline, no stalls.
module context_quant #(
   parameter int IMAGE_W = 256,
   parameter int IMAGE_H = 256,
   parameter int T1      = 3,
   parameter int T2      = 7,
   parameter int T3      = 21,
   parameter int NEAR    = 0
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        in_en,
   input  logic [15:0] Rx,
   input  logic [15:0] Ra,
   input  logic [15:0] Rb,
   input  logic [15:0] Rc,
   input  logic [16:0] D1,
   input  logic [16:0] D2,
   input  logic [16:0] D3,
   output logic        out_valid,
   output logic [8:0]  ctx_q,
   output logic        ctx_sign,
   output logic        run_flag,
   output logic [15:0] Px,
   output logic [15:0] Rx_o,
   output logic [15:0] Ra_o,
   output logic        sol,
   output logic        eol,
   output logic        eof
);

   localparam int CW = (IMAGE_W > 1) ? $clog2(IMAGE_W) : 1;
   localparam int RW = (IMAGE_H > 1) ? $clog2(IMAGE_H) : 1;
   localparam logic [CW-1:0] COL_LAST = CW'(IMAGE_W - 1);
   localparam logic [RW-1:0] ROW_LAST = RW'(IMAGE_H - 1);

   // Thresholds widened to 18 bits so the negated forms never overflow.
   localparam logic signed [17:0] T1_S   = 18'(T1);
   localparam logic signed [17:0] T2_S   = 18'(T2);
   localparam logic signed [17:0] T3_S   = 18'(T3);
   localparam logic signed [17:0] NEAR_S = 18'(NEAR);

   // Map a signed gradient onto the nine quantization regions -4..4.
   function automatic logic signed [3:0] quant(input logic [16:0] d);
      logic signed [17:0] dd;
      dd = {d[16], d};
      if (dd <= -T3_S)        quant = -4'sd4;
      else if (dd <= -T2_S)   quant = -4'sd3;
      else if (dd <= -T1_S)   quant = -4'sd2;
      else if (dd < -NEAR_S)  quant = -4'sd1;
      else if (dd <= NEAR_S)  quant =  4'sd0;
      else if (dd < T1_S)     quant =  4'sd1;
      else if (dd < T2_S)     quant =  4'sd2;
      else if (dd < T3_S)     quant =  4'sd3;
      else                    quant =  4'sd4;
   endfunction

   // Position counters
   logic [CW-1:0] col_q, col_d;
   logic [RW-1:0] row_q, row_d;

   // Stage 1 registers
   logic               v1_q, v1_d;
   logic signed [3:0]  q1_q, q1_d, q2_q, q2_d, q3_q, q3_d;
   logic [15:0]        mn_q, mn_d, mx_q, mx_d;
   logic [15:0]        ra_q, ra_d, rb_q, rb_d, rc_q, rc_d, rx_q, rx_d;
   logic               sol1_q, sol1_d, eol1_q, eol1_d, eof1_q, eof1_d;

   // Stage 2 (output) registers
   logic               ov_q, ov_d;
   logic [8:0]         ctx_qq, ctx_d;
   logic               sign_q, sign_d, run_q, run_d;
   logic [15:0]        px_q, px_d, rxo_q, rxo_d, rao_q, rao_d;
   logic               sol_q, sol_d, eol_q, eol_d, eof_q, eof_d;

   // Stage 2 combinational terms
   logic               neg_s;
   logic signed [3:0]  m1_s, m2_s, m3_s;
   logic signed [8:0]  ctx_s;
   logic [15:0]        px_s;

   // Stage 1: quantize, order Ra/Rb, tag frame position and advance counters.
   always_comb begin
      col_d  = col_q;
      row_d  = row_q;
      v1_d   = in_en;
      q1_d   = q1_q;
      q2_d   = q2_q;
      q3_d   = q3_q;
      mn_d   = mn_q;
      mx_d   = mx_q;
      ra_d   = ra_q;
      rb_d   = rb_q;
      rc_d   = rc_q;
      rx_d   = rx_q;
      sol1_d = 1'b0;
      eol1_d = 1'b0;
      eof1_d = 1'b0;
      if (in_en) begin
         q1_d   = quant(D1);
         q2_d   = quant(D2);
         q3_d   = quant(D3);
         ra_d   = Ra;
         rb_d   = Rb;
         rc_d   = Rc;
         rx_d   = Rx;
         sol1_d = (col_q == {CW{1'b0}});
         eol1_d = (col_q == COL_LAST);
         eof1_d = (col_q == COL_LAST) && (row_q == ROW_LAST);
         if (Ra < Rb) begin
            mn_d = Ra;
            mx_d = Rb;
         end else begin
            mn_d = Rb;
            mx_d = Ra;
         end
         if (col_q == COL_LAST) begin
            col_d = {CW{1'b0}};
            if (row_q == ROW_LAST) begin
               row_d = {RW{1'b0}};
            end else begin
               row_d = row_q + RW'(1);
            end
         end else begin
            col_d = col_q + CW'(1);
         end
      end else begin
         col_d = col_q;
      end
   end

   // Stage 2: sign-merge the context, build the index and the MED predictor.
   always_comb begin
      neg_s = (q1_q < 4'sd0) ||
              ((q1_q == 4'sd0) && ((q2_q < 4'sd0) ||
                                   ((q2_q == 4'sd0) && (q3_q < 4'sd0))));
      if (neg_s) begin
         m1_s = -q1_q;
         m2_s = -q2_q;
         m3_s = -q3_q;
      end else begin
         m1_s = q1_q;
         m2_s = q2_q;
         m3_s = q3_q;
      end
      // Modulo-512 arithmetic is exact because the true index lies in 0..364.
      ctx_s = {{5{m1_s[3]}}, m1_s} * 9'sd81 +
              {{5{m2_s[3]}}, m2_s} * 9'sd9 +
              {{5{m3_s[3]}}, m3_s};
      if (rc_q >= mx_q) begin
         px_s = mn_q;
      end else if (rc_q <= mn_q) begin
         px_s = mx_q;
      end else begin
         px_s = 16'({2'b00, ra_q} + {2'b00, rb_q} - {2'b00, rc_q});
      end

      ov_d  = v1_q;
      ctx_d = 9'd0;
      sign_d = 1'b0;
      run_d = 1'b0;
      sol_d = 1'b0;
      eol_d = 1'b0;
      eof_d = 1'b0;
      px_d  = px_q;
      rxo_d = rxo_q;
      rao_d = rao_q;
      if (v1_q) begin
         ctx_d  = ctx_s;
         sign_d = neg_s;
         run_d  = (q1_q == 4'sd0) && (q2_q == 4'sd0) && (q3_q == 4'sd0);
         sol_d  = sol1_q;
         eol_d  = eol1_q;
         eof_d  = eof1_q;
         px_d   = px_s;
         rxo_d  = rx_q;
         rao_d  = ra_q;
      end else begin
         ctx_d = 9'd0;
      end
   end

   // All state: asynchronous clear discards in-flight data and restarts at (0,0).
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         col_q  <= {CW{1'b0}};
         row_q  <= {RW{1'b0}};
         v1_q   <= 1'b0;
         q1_q   <= 4'sd0;
         q2_q   <= 4'sd0;
         q3_q   <= 4'sd0;
         mn_q   <= 16'd0;
         mx_q   <= 16'd0;
         ra_q   <= 16'd0;
         rb_q   <= 16'd0;
         rc_q   <= 16'd0;
         rx_q   <= 16'd0;
         sol1_q <= 1'b0;
         eol1_q <= 1'b0;
         eof1_q <= 1'b0;
         ov_q   <= 1'b0;
         ctx_qq <= 9'd0;
         sign_q <= 1'b0;
         run_q  <= 1'b0;
         px_q   <= 16'd0;
         rxo_q  <= 16'd0;
         rao_q  <= 16'd0;
         sol_q  <= 1'b0;
         eol_q  <= 1'b0;
         eof_q  <= 1'b0;
      end else begin
         col_q  <= col_d;
         row_q  <= row_d;
         v1_q   <= v1_d;
         q1_q   <= q1_d;
         q2_q   <= q2_d;
         q3_q   <= q3_d;
         mn_q   <= mn_d;
         mx_q   <= mx_d;
         ra_q   <= ra_d;
         rb_q   <= rb_d;
         rc_q   <= rc_d;
         rx_q   <= rx_d;
         sol1_q <= sol1_d;
         eol1_q <= eol1_d;
         eof1_q <= eof1_d;
         ov_q   <= ov_d;
         ctx_qq <= ctx_d;
         sign_q <= sign_d;
         run_q  <= run_d;
         px_q   <= px_d;
         rxo_q  <= rxo_d;
         rao_q  <= rao_d;
         sol_q  <= sol_d;
         eol_q  <= eol_d;
         eof_q  <= eof_d;
      end
   end

   assign out_valid = ov_q;
   assign ctx_q     = ctx_qq;
   assign ctx_sign  = sign_q;
   assign run_flag  = run_q;
   assign Px        = px_q;
   assign Rx_o      = rxo_q;
   assign Ra_o      = rao_q;
   assign sol       = sol_q;
   assign eol       = eol_q;
   assign eof       = eof_q;

endmodule

// File: doc/context_quant.md
CONTEXT_QUANT -- requirements
Module: context_quant

Interface
REQ-001 Parameter IMAGE_W, default 256, pixels per line.
REQ-002 Parameter IMAGE_H, default 256, lines per frame.
REQ-003 Parameters T1, T2, T3, defaults 3, 7, 21, gradient thresholds; NEAR, default 0, lossless bound.
REQ-004 clk  in  1  sole clock; all state is updated on its rising edge.
REQ-005 rst_n  in  1  asynchronous reset, active-low.
REQ-006 in_en  in  1  a neighbourhood/gradient set is present this cycle.
REQ-007 Rx, Ra, Rb, Rc  in  16 each  current pixel and neighbours, unsigned.
REQ-008 D1, D2, D3  in  17 each  gradients, two's-complement signed.
REQ-009 out_valid  out  1  output set valid.
REQ-010 ctx_q  out  9  merged context index, 0..364.
REQ-011 ctx_sign  out  1  context sign flag.
REQ-012 run_flag  out  1  run-mode context (all quantized gradients zero).
REQ-013 Px  out  16  MED prediction.
REQ-014 Rx_o, Ra_o  out  16 each  Rx and Ra delayed to align with Px.
REQ-015 sol, eol, eof  out  1 each  first pixel of line, last pixel of line, last pixel of frame.

Function
REQ-016 The block is a fixed 2-stage pipeline with no back-pressure; each in_en=1 sample appears with out_valid=1 exactly 2 cycles later, and in_en=0 cycles propagate as out_valid=0 bubbles.
REQ-017 Stage 1 quantizes each Di to Qi: Di<=-T3 ->-4; <=-T2 ->-3; <=-T1 ->-2; <-NEAR ->-1; <=NEAR ->0; <T1 ->1; <T2 ->2; <T3 ->3; else 4.
REQ-018 Stage 1 registers min(Ra,Rb), max(Ra,Rb), Ra, Rb, Rc, Rx, and the frame-position flags.
REQ-019 Stage 2 sign merge: if the first nonzero of (Q1,Q2,Q3) is negative, all three are negated and ctx_sign=1; otherwise ctx_sign=0.
REQ-020 Stage 2 computes ctx_q=(Q1*9+Q2)*9+Q3 on the merged values; the result is always within 0..364.
REQ-021 run_flag=1 iff Q1=Q2=Q3=0; in that case ctx_q=0 and ctx_sign=0.
REQ-022 MED: Px=min(Ra,Rb) if Rc>=max(Ra,Rb); Px=max(Ra,Rb) if Rc<=min(Ra,Rb); else Px=Ra+Rb-Rc.
REQ-023 The Ra+Rb-Rc term is computed at 18 bits or more, with no intermediate overflow, and the result is truncated to 16 bits.
REQ-024 Column counter (0..IMAGE_W-1) and row counter (0..IMAGE_H-1) advance only on in_en=1.
REQ-025 The column counter wraps at IMAGE_W-1 and increments the row counter.
REQ-026 The row counter wraps at IMAGE_H-1 when the column counter also wraps, so the next frame starts at (0,0).
REQ-027 sol=1 for column 0; eol=1 for column IMAGE_W-1; eof=1 for column IMAGE_W-1 together with row IMAGE_H-1.
REQ-028 sol, eol and eof are sampled with the pixel and delivered aligned with its out_valid.
REQ-029 When out_valid=0, ctx_q, ctx_sign, run_flag, sol, eol and eof are 0; Px, Rx_o and Ra_o hold their last values.
REQ-030 Extreme gradient 17'h10000 (-65536) yields Q=-4; 17'h0FFFF yields Q=4.
REQ-031 Back-to-back in_en for a full frame is sustained at one pixel per cycle with no dropped samples.

Reset
REQ-032 When rst_n=0, all pipeline valids, counters and outputs clear to 0 immediately, without waiting for a clock edge.
REQ-033 Data in flight when rst_n=0 is discarded and never emitted.
REQ-034 After rst_n rises, the first in_en=1 sample is treated as row 0, column 0.

Verification
REQ-035 D1=D2=D3=0, Ra=Rb=Rc=Rx=100, in_en pulse -> 2 cycles later out_valid=1, run_flag=1, ctx_q=0, ctx_sign=0, Px=100, Rx_o=100.
REQ-036 D1=5, D2=-1, D3=25 -> Q=(2,-1,4), ctx_sign=0, ctx_q=157; then D1=-8, D2=0, D3=2 -> merged (3,0,-1), ctx_sign=1, ctx_q=242.
REQ-037 Ra=50, Rb=80, with Rc=90 / 60 / 40 on consecutive cycles -> Px=50 / 70 / 80 on 3 consecutive out_valid cycles.
REQ-038 IMAGE_W=4, IMAGE_H=2, 8 continuous in_en then 8 more -> sol on outputs 1 and 5, eol on outputs 4 and 8, eof on output 8; the pattern repeats for the second frame.
REQ-039 D1=17'h10000, D2=17'h0FFFF, D3=0 -> Q=(-4,4,0), merged (4,-4,0), ctx_sign=1, ctx_q=288.
REQ-040 rst_n pulsed low while 2 samples are in flight -> out_valid=0 at once, no stale output after release, and the next sample reports sol=1.
